// File: rtl/karatsuba_pkg.sv
// Shared definitions for the iterative Karatsuba multiplier: FSM encoding,
// half-width helper and an elaboration-time operand width check.
`ifndef KARATSUBA_PKG_SV
`define KARATSUBA_PKG_SV

// Rejects odd or too-narrow operand widths, and an overridden half width.
`define KARATSUBA_WIDTH_CHECK(n, h) \
    if ((((n) % 2) != 0) || ((n) < 4) || ((h) != ((n) / 2))) begin : g_width_error \
        $error("iterative_karatsuba_hs: N must be even and >= 4, H must equal N/2"); \
    end

package karatsuba_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LL   = 3'd1,
        HH   = 3'd2,
        MID  = 3'd3,
        COMB = 3'd4,
        DONE = 3'd5
    } state_e;

    function automatic int unsigned half_w(input int unsigned n);
        return n / 2;
    endfunction

endpackage

`endif

// File: rtl/karatsuba_half_mul.sv
// Combinational W x W -> 2W unsigned multiplier shared by the three Karatsuba
// partial products.
module karatsuba_half_mul #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/iterative_karatsuba_hs.sv
// Iterative Karatsuba multiplier with valid/ready handshakes and a global stall:
// three partial products on one shared half multiplier, then a combine step.
module iterative_karatsuba_hs
    import karatsuba_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned H = half_w(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           signed_mode,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] C,
    output logic           busy
);

    `KARATSUBA_WIDTH_CHECK(N, H)

    localparam int unsigned W  = H + 1;
    localparam int unsigned RW = 2 * N + 2;

    state_e state_q, state_d;

    logic [N-1:0]   xa_q, xb_q;
    logic           neg_q;
    logic [2*H-1:0] p0_q, p2_q;
    logic [2*W-1:0] p1_q;
    logic [2*N-1:0] c_q;
    logic           out_valid_q;

    logic [N-1:0]   mag_a, mag_b;
    logic [W-1:0]   sum_x, sum_y;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic [RW-1:0]  mid_wide, r_wide;
    logic [2*N-1:0] r, c_next;
    logic           unused_r_hi;

    // |-2^(N-1)| wraps to 2^(N-1), which is still correct as an unsigned magnitude.
    assign mag_a = (signed_mode && A[N-1]) ? -A : A;
    assign mag_b = (signed_mode && B[N-1]) ? -B : B;

    assign sum_x = {1'b0, xa_q[N-1:H]} + {1'b0, xa_q[H-1:0]};
    assign sum_y = {1'b0, xb_q[N-1:H]} + {1'b0, xb_q[H-1:0]};

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            LL: begin
                mul_a = {1'b0, xa_q[H-1:0]};
                mul_b = {1'b0, xb_q[H-1:0]};
            end
            HH: begin
                mul_a = {1'b0, xa_q[N-1:H]};
                mul_b = {1'b0, xb_q[N-1:H]};
            end
            MID: begin
                mul_a = sum_x;
                mul_b = sum_y;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    karatsuba_half_mul #(
        .W(W)
    ) u_half_mul (
        .a(mul_a),
        .b(mul_b),
        .p(mul_p)
    );

    // Combine step; the middle term p1-p2-p0 is never negative.
    always_comb begin
        mid_wide = RW'(p1_q) - RW'(p2_q) - RW'(p0_q);
        r_wide   = (RW'(p2_q) << N) + (mid_wide << H) + RW'(p0_q);
        r        = r_wide[2*N-1:0];
        c_next   = neg_q ? -r : r;
    end

    assign unused_r_hi = ^r_wide[RW-1:2*N];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = LL;
            LL:      state_d = HH;
            HH:      state_d = MID;
            MID:     state_d = COMB;
            COMB:    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            xa_q        <= '0;
            xb_q        <= '0;
            neg_q       <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        xa_q  <= mag_a;
                        xb_q  <= mag_b;
                        neg_q <= signed_mode & (A[N-1] ^ B[N-1]);
                    end
                end
                LL:   p0_q <= mul_p[2*H-1:0];
                HH:   p2_q <= mul_p[2*H-1:0];
                MID:  p1_q <= mul_p;
                COMB: begin
                    c_q         <= c_next;
                    out_valid_q <= 1'b1;
                end
                DONE: if (out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign C         = c_q;

endmodule

// File: tb/tb_iterative_karatsuba_hs.sv
// Scoreboard bench: directed 32-bit vectors with handshake/stall/reset cases, plus
// an 8-bit instance streamed back-to-back in both modes.
module tb_iterative_karatsuba_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst32, en32, iv32, rdy32, sm32, ov32, ordy32, busy32;
    logic [31:0] a32, b32;
    logic [63:0] c32;

    logic        rst8, en8, iv8, rdy8, sm8, ov8, ordy8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] c8;

    logic [63:0] q32[$];
    logic [15:0] q8[$];
    logic [63:0] exp32_m;
    logic [15:0] exp8_m;

    iterative_karatsuba_hs #(.N(32)) u_dut32 (
        .clk(clk), .rst(rst32), .enable(en32), .in_valid(iv32), .in_ready(rdy32),
        .signed_mode(sm32), .A(a32), .B(b32), .out_valid(ov32), .out_ready(ordy32),
        .C(c32), .busy(busy32)
    );

    iterative_karatsuba_hs #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst8), .enable(en8), .in_valid(iv8), .in_ready(rdy8),
        .signed_mode(sm8), .A(a8), .B(b8), .out_valid(ov8), .out_ready(ordy8),
        .C(c8), .busy(busy8)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    // Monitors: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst32 && en32 && ov32 && ordy32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out32: got 0x%0h, expected no output", c32);
            end else begin
                exp32_m = q32.pop_front();
                chk("product32", c32, exp32_m);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst8 && en8 && ov8 && ordy8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out8: got 0x%0h, expected no output", c8);
            end else begin
                exp8_m = q8.pop_front();
                chk("product8", {48'b0, c8}, {48'b0, exp8_m});
            end
        end
    end

    // Called #1 after a clock edge; returns #1 after the accept edge.
    task automatic send32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv, input bit push);
        int n = 0;
        sm32 = sm;
        a32  = a;
        b32  = b;
        iv32 = 1'b1;
        while (!(rdy32 && en32) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout32: got no in_ready, expected accept");
        end
        if (push) q32.push_back(expv);
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic wait_ov32(input int k0, input int lat, input string name);
        int k = k0;
        while (!ov32 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, 64'(k), 64'(lat));
    endtask

    task automatic run32();
        send32(1'b0, 32'd10, 32'd12, 64'd120, 1'b1);
        chk("busy_during_txn", {63'b0, busy32}, 64'd1);
        wait_ov32(0, 4, "latency_basic");
        @(posedge clk); #1;
        chk("busy_after_drain", {63'b0, busy32}, 64'd0);
        chk("in_ready_after_drain", {63'b0, rdy32}, 64'd1);
        chk("c_held_after_drain", c32, 64'd120);

        send32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        wait_ov32(0, 4, "latency_umax");
        send32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b1);
        wait_ov32(0, 4, "latency_sneg1");
        send32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        wait_ov32(0, 4, "latency_smin");
        send32(1'b1, 32'hFFFF_FFF9, 32'd12, 64'hFFFF_FFFF_FFFF_FFAC, 1'b1);
        wait_ov32(0, 4, "latency_sneg7");
        send32(1'b1, 32'd5, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        wait_ov32(0, 4, "latency_smixed");

        // Backpressure with a competing request that must not be accepted.
        @(posedge clk); #1;
        ordy32 = 1'b0;
        send32(1'b0, 32'd1000, 32'd1000, 64'd1000000, 1'b1);
        wait_ov32(0, 4, "latency_bp");
        iv32 = 1'b1;
        a32  = 32'd3;
        b32  = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_c_stable", c32, 64'd1000000);
            chk("bp_out_valid", {63'b0, ov32}, 64'd1);
            chk("bp_in_ready", {63'b0, rdy32}, 64'd0);
        end
        iv32   = 1'b0;
        ordy32 = 1'b1;
        @(posedge clk); #1;
        chk("bp_out_valid_drained", {63'b0, ov32}, 64'd0);
        @(posedge clk); #1;
        chk("bp_not_accepted", {63'b0, busy32}, 64'd0);

        // Three stalled cycles while in MID.
        send32(1'b0, 32'h0001_0000, 32'h0003_0000, 64'h0000_0003_0000_0000, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        en32 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        en32 = 1'b1;
        wait_ov32(5, 7, "latency_stall");

        // Reset during HH discards the transaction.
        send32(1'b0, 32'd5, 32'd6, 64'd30, 1'b0);
        @(posedge clk); #1;
        rst32 = 1'b1;
        @(posedge clk); #1;
        rst32 = 1'b0;
        chk("rst_mid_out_valid", {63'b0, ov32}, 64'd0);
        chk("rst_mid_c", c32, 64'd0);
        chk("rst_mid_in_ready", {63'b0, rdy32}, 64'd1);
        send32(1'b0, 32'd3, 32'd5, 64'd15, 1'b1);
        wait_ov32(0, 4, "latency_after_rst");
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic send8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                         inout int last_acc);
        int n = 0;
        logic signed [15:0] sp;
        logic [15:0] up;
        sm8 = sm;
        a8  = a;
        b8  = b;
        sp  = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
        up  = {8'b0, a} * {8'b0, b};
        while (!rdy8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout8: got no in_ready, expected accept");
        end
        q8.push_back(sm ? sp : up);
        @(posedge clk); #1;
        if (last_acc >= 0) chk("ii8", 64'(cyc - last_acc), 64'd6);
        last_acc = cyc;
    endtask

    task automatic run8();
        int last_acc = -1;
        logic [7:0] corners [6];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};
        iv8 = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) begin
                send8(m[0], 8'(i), 8'((i * 37 + 11) & 255), last_acc);
            end
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    send8(m[0], corners[i], corners[j], last_acc);
                end
            end
        end
        iv8 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst32 = 1'b1; en32 = 1'b1; iv32 = 1'b0; sm32 = 1'b0; ordy32 = 1'b1;
        a32 = '0; b32 = '0;
        rst8 = 1'b1; en8 = 1'b1; iv8 = 1'b0; sm8 = 1'b0; ordy8 = 1'b1;
        a8 = '0; b8 = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst32 = 1'b0;
        rst8  = 1'b0;
        chk("reset_c", c32, 64'd0);
        chk("reset_out_valid", {63'b0, ov32}, 64'd0);
        chk("reset_in_ready", {63'b0, rdy32}, 64'd1);
        chk("reset_busy", {63'b0, busy32}, 64'd0);

        fork
            run32();
            run8();
        join

        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 64'(q32.size() + q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
